// File: rtl/mem_read_data_decoder.sv
// Load-data aligner: captures a load request, waits for the memory word (with timeout),
// then returns the selected byte/half/word lane, sign- or zero-extended, under a valid/ready handshake.
module mem_read_data_decoder #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic [1:0]  offSet,
    input  logic [1:0]  dataSize,
    input  logic        signExt,
    output logic        reqReady,
    input  logic        memDataValid,
    input  logic [31:0] memData,
    output logic [31:0] outData,
    output logic        outValid,
    input  logic        outReady,
    output logic        misAlign,
    output logic        timeoutErr
);
    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sext_q;

    function automatic logic illegal_access(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (sz)
            SZ_WORD: bad = (off != 2'd0);
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes are big-endian: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] decode(input logic [31:0] d, input logic [1:0] off,
                                           input logic [1:0] sz, input logic se);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = off[1] ? d[15:0] : d[31:16];
        case (sz)
            SZ_HALF: r = {{16{se & h[15]}}, h};
            SZ_BYTE: r = {{24{se & b[7]}}, b};
            default: r = d;
        endcase
        return r;
    endfunction

    assign reqReady = (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            sext_q     <= 1'b0;
            outData    <= 32'd0;
            outValid   <= 1'b0;
            misAlign   <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memRead) begin
                        off_q  <= offSet;
                        size_q <= dataSize;
                        sext_q <= signExt;
                        cnt    <= 8'd0;
                        if (illegal_access(dataSize, offSet)) begin
                            state      <= RESP;
                            outValid   <= 1'b1;
                            misAlign   <= 1'b1;
                            timeoutErr <= 1'b0;
                            outData    <= 32'd0;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Data arriving on the timeout cycle takes priority over the timeout.
                    if (memDataValid) begin
                        state      <= RESP;
                        outValid   <= 1'b1;
                        misAlign   <= 1'b0;
                        timeoutErr <= 1'b0;
                        outData    <= decode(memData, off_q, size_q, sext_q);
                    end else if (cnt == CNT_LAST) begin
                        state      <= RESP;
                        outValid   <= 1'b1;
                        misAlign   <= 1'b0;
                        timeoutErr <= 1'b1;
                        outData    <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (outReady) begin
                        state      <= IDLE;
                        outValid   <= 1'b0;
                        misAlign   <= 1'b0;
                        timeoutErr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_read_data_decoder.sv
// Directed bench for mem_read_data_decoder: lane select/extension, illegal accesses,
// timeout and its data-wins corner, response stall, and asynchronous reset abort.
module tb_mem_read_data_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        memRead;
    logic [1:0]  offSet;
    logic [1:0]  dataSize;
    logic        signExt;
    logic        reqReady;
    logic        memDataValid;
    logic [31:0] memData;
    logic [31:0] outData;
    logic        outValid;
    logic        outReady;
    logic        misAlign;
    logic        timeoutErr;

    int passed = 0;
    int total  = 0;

    mem_read_data_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .offSet(offSet), .dataSize(dataSize),
        .signExt(signExt), .reqReady(reqReady), .memDataValid(memDataValid), .memData(memData),
        .outData(outData), .outValid(outValid), .outReady(outReady), .misAlign(misAlign),
        .timeoutErr(timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic request(input logic [1:0] sz, input logic [1:0] off, input logic se);
        memRead = 1'b1; dataSize = sz; offSet = off; signExt = se;
        step();
        memRead = 1'b0;
    endtask

    // Expect a response of (data, misAlign, timeoutErr), then complete the handshake.
    task automatic expect_resp(input string tag, input logic [31:0] d, input logic ma, input logic te);
        check({tag, ".valid"}, {31'd0, outValid}, 32'd1);
        check({tag, ".data"}, outData, d);
        check({tag, ".mis"}, {31'd0, misAlign}, {31'd0, ma});
        check({tag, ".tmo"}, {31'd0, timeoutErr}, {31'd0, te});
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        check({tag, ".idle"}, {30'd0, outValid, reqReady}, 32'd1);
    endtask

    task automatic data_load(input string tag, input logic [1:0] sz, input logic [1:0] off,
                             input logic se, input logic [31:0] word, input logic [31:0] exp);
        request(sz, off, se);
        memDataValid = 1'b1; memData = word;
        step();
        memDataValid = 1'b0;
        expect_resp(tag, exp, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; memRead = 1'b0; offSet = 2'd0; dataSize = 2'd0; signExt = 1'b0;
        memDataValid = 1'b0; memData = 32'd0; outReady = 1'b0;
        step(); step();
        check("rst.outs", {outData[0], outValid, misAlign, timeoutErr, reqReady}, 32'd1);
        check("rst.data", outData, 32'd0);
        rst = 1'b1;
        step();

        // Byte, offset 1, sign-extend, data after 3 wait cycles
        request(2'd2, 2'd1, 1'b1);
        check("b1.busy", {31'd0, reqReady}, 32'd0);
        step(); step();
        check("b1.wait", {31'd0, outValid}, 32'd0);
        memDataValid = 1'b1; memData = 32'h1280FF34;
        step();
        memDataValid = 1'b0;
        expect_resp("b1", 32'hFFFFFF80, 1'b0, 1'b0);
        check("b1.hold", outData, 32'hFFFFFF80);

        data_load("h2z", 2'd1, 2'd2, 1'b0, 32'hAAAA8001, 32'h00008001);
        data_load("h2s", 2'd1, 2'd2, 1'b1, 32'hAAAA8001, 32'hFFFF8001);
        data_load("h0s", 2'd1, 2'd0, 1'b1, 32'h7FFE1234, 32'h00007FFE);
        data_load("b3z", 2'd2, 2'd3, 1'b0, 32'h000000F0, 32'h000000F0);
        data_load("b0s", 2'd2, 2'd0, 1'b1, 32'h9C000000, 32'hFFFFFF9C);
        data_load("w0",  2'd0, 2'd0, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);

        // Illegal accesses respond next cycle; memDataValid must not matter
        memDataValid = 1'b1; memData = 32'h12345678;
        request(2'd0, 2'd2, 1'b0);
        memDataValid = 1'b0;
        expect_resp("w2ill", 32'd0, 1'b1, 1'b0);
        request(2'd1, 2'd1, 1'b1);
        expect_resp("h1ill", 32'd0, 1'b1, 1'b0);
        request(2'd3, 2'd0, 1'b0);
        expect_resp("sz3ill", 32'd0, 1'b1, 1'b0);

        // Timeout after 16 silent WAIT cycles
        request(2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 15; i++) step();
        check("tmo.pre", {31'd0, outValid}, 32'd0);
        step();
        expect_resp("tmo", 32'd0, 1'b0, 1'b1);

        // Data on the 16th cycle wins over the timeout
        request(2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 15; i++) step();
        memDataValid = 1'b1; memData = 32'hDEADBEEF;
        step();
        memDataValid = 1'b0;
        expect_resp("tmowin", 32'hDEADBEEF, 1'b0, 1'b0);

        // Stall in RESP: outputs stable, stray memRead/memDataValid ignored
        request(2'd2, 2'd2, 1'b1);
        memDataValid = 1'b1; memData = 32'h00007F00;
        step();
        memDataValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            memRead = i[0]; memDataValid = ~i[0]; memData = 32'hFFFFFFFF; dataSize = 2'd3;
            step();
            check("stall", {27'd0, outValid, misAlign, timeoutErr, reqReady, 1'b0}, 32'h10);
            check("stall.data", outData, 32'h0000007F);
        end
        memRead = 1'b0; memDataValid = 1'b0;
        expect_resp("stall", 32'h0000007F, 1'b0, 1'b0);
        request(2'd0, 2'd1, 1'b0);
        expect_resp("b2b", 32'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-WAIT aborts the load
        request(2'd0, 2'd0, 1'b0);
        step();
        #2 rst = 1'b0;
        #1;
        check("arst.outs", {29'd0, outValid, misAlign, timeoutErr}, 32'd0);
        check("arst.data", outData, 32'd0);
        check("arst.ready", {31'd0, reqReady}, 32'd1);
        step();
        rst = 1'b1;
        memDataValid = 1'b1; memData = 32'h55555555;
        step(); step();
        memDataValid = 1'b0;
        check("arst.late", {30'd0, outValid, reqReady}, 32'd1);
        data_load("post", 2'd2, 2'd3, 1'b1, 32'h00000080, 32'hFFFFFF80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
